// File: rtl/cpu_pkg.sv
// Shared types and helpers for the interrupt controller.
// Holds the FSM state enum, source count and priority encoder.
package cpu_pkg;

    localparam int NUM_IRQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Lowest set index wins.
    function automatic logic [ID_W-1:0] prio_enc(
        input logic [NUM_IRQ-1:0] v
    );
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle between the control unit (master) and intr_ctrl (slave).
// Ports: irq, ie, gie_set/gie_clr, int_ack, reti in; int_req/vec/id, in_service, pending out.
interface intr_ctrl_if
    import cpu_pkg::*;
#(
    parameter int PC_W = 10
);
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] ie;
    logic               gie_set;
    logic               gie_clr;
    logic               int_ack;
    logic               reti;
    logic               int_req;
    logic [PC_W-1:0]    int_vec;
    logic [ID_W-1:0]    int_id;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq, ie, gie_set, gie_clr, int_ack, reti,
        input  int_req, int_vec, int_id, in_service, pending
    );

    modport slave (
        input  irq, ie, gie_set, gie_clr, int_ack, reti,
        output int_req, int_vec, int_id, in_service, pending
    );

endinterface

// File: rtl/intr_ctrl_irq_pend.sv
// Rising-edge detection and latched pending flags per source.
// Ports: clk, reset, irq in, clr/clr_id (ack of one source) in, pending out.
module irq_pend
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               clr,
    input  logic [ID_W-1:0]    clr_id,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_mask;

    // History resets to 0 so a line held high across reset counts as an edge.
    assign rise     = irq & ~irq_q;
    assign clr_mask = clr ? (NUM_IRQ'(1) << clr_id) : '0;

    // A new edge in the ack cycle overrides the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr_mask) | rise;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: IDLE/REQ/SERVICE sequencing, global enable, vectoring.
// Ports: clk, reset (sync, active-high), bus (intr_ctrl_if.slave).
module intr_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(10'h3FC)
)(
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    state_e             state;
    logic               gie;
    logic [ID_W-1:0]    id_q;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] eligible;
    logic               ack_take;
    logic               reti_take;

    // Strobes only act in their own state.
    assign ack_take  = (state == REQ) && bus.int_ack;
    assign reti_take = (state == SERVICE) && bus.reti;
    assign eligible  = pend & bus.ie;

    irq_pend u_pend (
        .clk     (clk),
        .reset   (reset),
        .irq     (bus.irq),
        .clr     (ack_take),
        .clr_id  (id_q),
        .pending (pend)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            id_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gie && (|eligible)) begin
                        state <= REQ;
                        id_q  <= prio_enc(eligible);
                    end
                end
                REQ: begin
                    if (bus.int_ack)      state <= SERVICE;
                    else if (bus.gie_clr) state <= IDLE;
                end
                SERVICE: begin
                    if (bus.reti) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clears (ack, DI) dominate sets (EI, reti).
    always_ff @(posedge clk) begin
        if (reset) begin
            gie <= 1'b0;
        end else if (ack_take || bus.gie_clr) begin
            gie <= 1'b0;
        end else if (bus.gie_set || reti_take) begin
            gie <= 1'b1;
        end
    end

    assign bus.int_req    = (state == REQ);
    assign bus.in_service = (state == SERVICE);
    assign bus.int_id     = id_q;
    assign bus.pending    = pend;
    assign bus.int_vec    = reset ? VEC_BASE
                                  : VEC_BASE + PC_W'(id_q);

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed strobes, queued expectations,
// negedge monitor compares.
module tb_intr_ctrl;
    import cpu_pkg::*;

    typedef struct {
        string      name;
        logic       req;
        logic [1:0] id;
        logic [9:0] vec;
        logic       svc;
        logic [3:0] pend;
        bit         cid;
        bit         cvec;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];

    intr_ctrl_if #(.PC_W(10)) bus();

    intr_ctrl #(.PC_W(10), .VEC_BASE(10'h3FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic req,
                            input logic [1:0] id, input logic [9:0] vec,
                            input logic svc, input logic [3:0] pend,
                            input bit cid, input bit cvec);
        exp_t e;
        e.name = name; e.req = req; e.id = id; e.vec = vec;
        e.svc = svc; e.pend = pend; e.cid = cid; e.cvec = cvec;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            bit   bad;
            e = q.pop_front();
            bad = (bus.int_req !== e.req) || (bus.in_service !== e.svc) ||
                  (bus.pending !== e.pend) ||
                  (e.cid && (bus.int_id !== e.id)) ||
                  (e.cvec && (bus.int_vec !== e.vec));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got req=%b id=%0d vec=%h svc=%b pend=%b, want req=%b id=%0d vec=%h svc=%b pend=%b",
                         e.name, bus.int_req, bus.int_id, bus.int_vec,
                         bus.in_service, bus.pending, e.req, e.id, e.vec,
                         e.svc, e.pend);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.irq = '0; bus.ie = '0;
        bus.gie_set = 0; bus.gie_clr = 0; bus.int_ack = 0; bus.reti = 0;
        cyc(); cyc();
        push_exp("reset", 0, 0, 10'h3FC, 0, 4'h0, 1, 1);
        reset = 1'b0;
        cyc();
        // single source
        bus.ie = 4'hF; bus.gie_set = 1; cyc(); bus.gie_set = 0;
        push_exp("gie_on", 0, 0, 0, 0, 4'h0, 0, 0);
        bus.irq = 4'b0100; cyc(); bus.irq = 0;
        push_exp("pend2", 0, 0, 0, 0, 4'b0100, 0, 0);
        cyc();
        push_exp("req2", 1, 2, 10'h3FE, 0, 4'b0100, 1, 1);
        bus.int_ack = 1; cyc(); bus.int_ack = 0;
        push_exp("svc2", 0, 2, 0, 1, 4'h0, 1, 0);
        bus.reti = 1; cyc(); bus.reti = 0;
        push_exp("reti2", 0, 0, 0, 0, 4'h0, 0, 0);
        // simultaneous edges on 3 and 1
        bus.irq = 4'b1010; cyc(); bus.irq = 0;
        push_exp("pend31", 0, 0, 0, 0, 4'b1010, 0, 0);
        cyc();
        push_exp("req1", 1, 1, 10'h3FD, 0, 4'b1010, 1, 1);
        bus.int_ack = 1; cyc(); bus.int_ack = 0;
        push_exp("svc1", 0, 1, 0, 1, 4'b1000, 1, 0);
        bus.reti = 1; cyc(); bus.reti = 0;
        push_exp("reti1", 0, 0, 0, 0, 4'b1000, 0, 0);
        cyc();
        push_exp("req3", 1, 3, 10'h3FF, 0, 4'b1000, 1, 1);
        bus.int_ack = 1; cyc(); bus.int_ack = 0;
        push_exp("svc3", 0, 3, 0, 1, 4'h0, 1, 0);
        bus.reti = 1; cyc(); bus.reti = 0;
        push_exp("reti3", 0, 0, 0, 0, 4'h0, 0, 0);
        // gie off: pending latches, no request
        bus.gie_clr = 1; cyc(); bus.gie_clr = 0;
        bus.irq = 4'b0001; cyc(); bus.irq = 0;
        push_exp("gie0_pend", 0, 0, 0, 0, 4'b0001, 0, 0);
        cyc();
        push_exp("gie0_hold", 0, 0, 0, 0, 4'b0001, 0, 0);
        bus.gie_set = 1; cyc(); bus.gie_set = 0;
        push_exp("ei_lat1", 0, 0, 0, 0, 4'b0001, 0, 0);
        cyc();
        push_exp("ei_req0", 1, 0, 10'h3FC, 0, 4'b0001, 1, 1);
        // DI while requesting
        bus.gie_clr = 1; cyc(); bus.gie_clr = 0;
        push_exp("di_drop", 0, 0, 0, 0, 4'b0001, 0, 0);
        bus.gie_set = 1; bus.gie_clr = 1; cyc();
        bus.gie_set = 0; bus.gie_clr = 0;
        push_exp("clr_wins_a", 0, 0, 0, 0, 4'b0001, 0, 0);
        cyc();
        push_exp("clr_wins_b", 0, 0, 0, 0, 4'b0001, 0, 0);
        bus.gie_set = 1; cyc(); bus.gie_set = 0;
        cyc();
        push_exp("rereq0", 1, 0, 10'h3FC, 0, 4'b0001, 1, 1);
        bus.int_ack = 1; bus.gie_clr = 1; cyc();
        bus.int_ack = 0; bus.gie_clr = 0;
        push_exp("ack_wins", 0, 0, 0, 1, 4'h0, 1, 0);
        // no nesting; stray ack ignored
        bus.irq = 4'b0001; cyc(); bus.irq = 0;
        push_exp("svc_edge", 0, 0, 0, 1, 4'b0001, 0, 0);
        bus.gie_set = 1; cyc(); bus.gie_set = 0;
        push_exp("svc_ei", 0, 0, 0, 1, 4'b0001, 0, 0);
        bus.int_ack = 1; cyc(); bus.int_ack = 0;
        push_exp("svc_ack_ign", 0, 0, 0, 1, 4'b0001, 0, 0);
        bus.reti = 1; cyc(); bus.reti = 0;
        push_exp("svc_reti", 0, 0, 0, 0, 4'b0001, 0, 0);
        cyc();
        push_exp("post_req0", 1, 0, 10'h3FC, 0, 4'b0001, 1, 1);
        bus.reti = 1; bus.ie = 4'h0; cyc(); bus.reti = 0;
        push_exp("req_frozen", 1, 0, 10'h3FC, 0, 4'b0001, 1, 1);
        bus.ie = 4'hF;
        // ack coincident with a new edge on the same source
        bus.int_ack = 1; bus.irq = 4'b0001; cyc();
        bus.int_ack = 0; bus.irq = 0;
        push_exp("ack_edge", 0, 0, 0, 1, 4'b0001, 1, 0);
        // reset in service with all lines high
        bus.irq = 4'hF; reset = 1; cyc();
        push_exp("rst_svc", 0, 0, 10'h3FC, 0, 4'h0, 1, 1);
        cyc();
        push_exp("rst_hold", 0, 0, 10'h3FC, 0, 4'h0, 1, 1);
        reset = 0; cyc();
        push_exp("rst_edge", 0, 0, 0, 0, 4'hF, 0, 0);
        cyc();
        push_exp("rst_nogie", 0, 0, 0, 0, 4'hF, 0, 0);
        bus.gie_set = 1; cyc(); bus.gie_set = 0;
        cyc();
        push_exp("rst_req0", 1, 0, 10'h3FC, 0, 4'hF, 1, 1);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter PC_W, default 10, SHALL set the program-counter and vector width.
REQ-002 Parameter VEC_BASE, default 10'h3FC, SHALL set the vector of source 0; source k vectors to VEC_BASE+k, modulo 2^PC_W.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq  in  4  raw interrupt lines, already synchronous to clk; bit k is source k.
REQ-006 ie  in  4  per-source enables, matching the CPU's ie1..ie4 (ie[0]=ie1).
REQ-007 gie_set, gie_clr  in  1 each  one-cycle strobes from the control unit (EI/DI instructions).
REQ-008 int_ack  in  1  one-cycle strobe from the control unit once the PC has been pushed and the vector loaded.
REQ-009 reti  in  1  one-cycle strobe for return-from-interrupt.
REQ-010 int_req  out  1  interrupt request to the control unit.
REQ-011 int_vec  out  PC_W  target vector; valid while int_req=1.
REQ-012 int_id  out  2  source being requested or serviced.
REQ-013 in_service  out  1  high while a handler is running.
REQ-014 pending  out  4  latched pending flags.

Function
REQ-015 pending[k] SHALL set on a rising edge of irq[k] (irq[k]=1, previous-cycle irq[k]=0), independent of ie and gie.
REQ-016 pending[k] SHALL clear only on the int_ack cycle for id k; a new edge on k in that cycle SHALL leave pending[k]=1.
REQ-017 Eligible set = pending & ie; priority SHALL be fixed, with the lowest index highest.
REQ-018 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-019 IDLE->REQ when gie=1 and the eligible set is nonzero; int_id SHALL latch the highest-priority eligible source on that transition.
REQ-020 In REQ: int_req=1, int_vec=VEC_BASE+int_id; int_id SHALL stay frozen even if ie or pending changes.
REQ-021 REQ->SERVICE on int_ack, which SHALL also clear pending[int_id] and gie.
REQ-022 REQ->IDLE on gie_clr without int_ack; pending SHALL be kept, and int_req SHALL drop the next cycle.
REQ-023 If int_ack and gie_clr arrive in the same cycle, int_ack SHALL win.
REQ-024 In SERVICE: in_service=1, int_req=0, no nesting; SERVICE->IDLE on reti, which SHALL set gie=1.
REQ-025 reti in IDLE or REQ SHALL be ignored; int_ack outside REQ SHALL be ignored.
REQ-026 If gie_set and gie_clr arrive together, gie_clr SHALL win; gie_set in SERVICE SHALL set gie but SHALL NOT leave SERVICE.
REQ-027 Latency: an irq edge sampled at edge n SHALL give pending=1 after n, and int_req=1 after edge n+1 (gie=1, ie=1, IDLE).
REQ-028 After reti, a still-eligible source SHALL produce int_req two edges later (IDLE then REQ).

Reset
REQ-029 On reset: state=IDLE, gie=0, pending=0, irq history=0, int_req=0, int_id=0, in_service=0.
REQ-030 int_vec SHALL read VEC_BASE while reset is high.
REQ-031 An irq line already high at reset release SHALL count as an edge.
REQ-032 Reset asserted in REQ or SERVICE SHALL abort the sequence with no ack or return.

Structure
REQ-033 cpu_pkg SHALL hold the state enum, NUM_IRQ=4, and a priority-encoder function.
REQ-034 Sub-module irq_pend SHALL hold the edge detection and pending flags; the FSM, gie and vector generation SHALL stay in intr_ctrl.

Verification
REQ-035 gie=1, ie=4'hF, pulse irq[2] -> pending=4'b0100, then int_req=1, int_id=2, int_vec=10'h3FE; int_ack -> pending=0, in_service=1.
REQ-036 Edges on irq[3] and irq[1] in the same cycle -> int_id=1 serviced first; after reti, int_id=3, int_vec=10'h3FF.
REQ-037 gie=0, pulse irq[0] -> no int_req and pending[0]=1; gie_set -> int_req two cycles later.
REQ-038 In REQ, assert gie_clr -> int_req drops and pending kept; int_ack with gie_clr in the same cycle -> SERVICE.
REQ-039 In SERVICE, new edge on irq[0] -> no int_req until reti, then int_id=0.
REQ-040 Reset asserted in SERVICE with irq held high -> all outputs zero; after release, pending=4'hF.
